// File: rtl/id_result_buffer_pkg.sv
// Shared types and default widths for the MAC coprocessor result buffer.
// Per-ID entry layout and counter width helper.
package id_result_buffer_pkg;

  localparam int unsigned IdWidthDef    = 3;
  localparam int unsigned DataWidthDef  = 32;
  localparam int unsigned RdWidthDef    = 5;
  localparam int unsigned QueueDepthDef = 4;

  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic [RdWidthDef-1:0]   rd;
    logic [DataWidthDef-1:0] data;
  } id_entry_t;

  function automatic int unsigned cnt_width(
    input int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/id_order_fifo.sv
// Pointer FIFO holding instruction IDs in issue order.
// Power-of-two depth so pointers wrap naturally.
module id_order_fifo
  import id_result_buffer_pkg::*;
#(
  parameter int unsigned IdWidth = IdWidthDef,
  parameter int unsigned Depth   = QueueDepthDef
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [IdWidth-1:0]          push_id_i,
  input  logic                        pop_i,
  output logic [IdWidth-1:0]          head_o,
  output logic [cnt_width(Depth)-1:0] count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = cnt_width(Depth);

  logic [IdWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]    wr_q;
  logic [PtrW-1:0]    rd_q;
  logic [CntW-1:0]    cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_id_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      if (push_i && !pop_i) cnt_q <= cnt_q + 1'b1;
      else if (!push_i && pop_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/id_result_buffer.sv
// In-order retire buffer for out-of-order MAC writebacks keyed by ID.
// Entry state lives here; issue order is kept by id_order_fifo.
module id_result_buffer
  import id_result_buffer_pkg::*;
#(
  parameter int unsigned IdWidth    = IdWidthDef,
  parameter int unsigned DataWidth  = DataWidthDef,
  parameter int unsigned RdWidth    = RdWidthDef,
  parameter int unsigned QueueDepth = QueueDepthDef
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             alloc_valid_i,
  output logic                             alloc_ready_o,
  input  logic [IdWidth-1:0]               alloc_id_i,
  input  logic [RdWidth-1:0]               alloc_rd_i,
  input  logic                             wb_valid_i,
  input  logic [IdWidth-1:0]               wb_id_i,
  input  logic [DataWidth-1:0]             wb_data_i,
  output logic                             result_valid_o,
  input  logic                             result_ready_i,
  output logic [IdWidth-1:0]               result_id_o,
  output logic [DataWidth-1:0]             result_data_o,
  output logic [RdWidth-1:0]               result_rd_o,
  output logic                             result_we_o,
  output logic [cnt_width(QueueDepth)-1:0] count_o,
  output logic                             err_o
);

  localparam int unsigned NumIds = 2 ** IdWidth;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [RdWidth-1:0]   rd;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t             ent_q [NumIds];
  entry_t             head_ent;
  logic [IdWidth-1:0] head_id;
  logic               full;
  logic               empty;
  logic               alloc_fire;
  logic               pop;
  logic               wb_ok;
  logic               wb_err;
  logic               err_q;

  id_order_fifo #(
    .IdWidth (IdWidth),
    .Depth   (QueueDepth)
  ) u_order (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .push_i    (alloc_fire),
    .push_id_i (alloc_id_i),
    .pop_i     (pop),
    .head_o    (head_id),
    .count_o   (count_o),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign head_ent = ent_q[head_id];

  // rst_ni gates ready so every output reads 0 while in reset
  assign alloc_ready_o = rst_ni && !flush_i && !full
                       && !ent_q[alloc_id_i].busy;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  assign result_valid_o = !flush_i && !empty && head_ent.done;
  assign pop            = result_valid_o && result_ready_i;

  assign wb_ok  = wb_valid_i && !flush_i
                && ent_q[wb_id_i].busy && !ent_q[wb_id_i].done;
  assign wb_err = wb_valid_i && !flush_i && !wb_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      err_q <= wb_err;
      if (flush_i) begin
        for (int i = 0; i < NumIds; i++) begin
          ent_q[i].busy <= 1'b0;
          ent_q[i].done <= 1'b0;
        end
      end else begin
        if (wb_ok) begin
          ent_q[wb_id_i].data <= wb_data_i;
          ent_q[wb_id_i].done <= 1'b1;
        end
        if (pop) begin
          ent_q[head_id].busy <= 1'b0;
          ent_q[head_id].done <= 1'b0;
        end
        if (alloc_fire) begin
          ent_q[alloc_id_i].busy <= 1'b1;
          ent_q[alloc_id_i].done <= 1'b0;
          ent_q[alloc_id_i].rd   <= alloc_rd_i;
        end
      end
    end
  end

  assign result_id_o   = head_id;
  assign result_data_o = head_ent.data;
  assign result_rd_o   = head_ent.rd;
  assign result_we_o   = |head_ent.rd;
  assign err_o         = err_q;

endmodule

// File: tb/tb_id_result_buffer.sv
// Scenario and randomized checks of id_result_buffer against a queue model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_id_result_buffer;

  localparam int IW = 3;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int QD = 4;
  localparam int CW = 3;
  localparam int NI = 8;

  logic          clk_i = 0;
  logic          rst_ni = 1;
  logic          flush_i = 0;
  logic          alloc_valid_i = 0;
  logic          alloc_ready_o;
  logic [IW-1:0] alloc_id_i = 0;
  logic [RW-1:0] alloc_rd_i = 0;
  logic          wb_valid_i = 0;
  logic [IW-1:0] wb_id_i = 0;
  logic [DW-1:0] wb_data_i = 0;
  logic          result_valid_o;
  logic          result_ready_i = 0;
  logic [IW-1:0] result_id_o;
  logic [DW-1:0] result_data_o;
  logic [RW-1:0] result_rd_o;
  logic          result_we_o;
  logic [CW-1:0] count_o;
  logic          err_o;

  id_result_buffer #(
    .IdWidth(IW), .DataWidth(DW), .RdWidth(RW), .QueueDepth(QD)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_id_i     (alloc_id_i),
    .alloc_rd_i     (alloc_rd_i),
    .wb_valid_i     (wb_valid_i),
    .wb_id_i        (wb_id_i),
    .wb_data_i      (wb_data_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_data_o  (result_data_o),
    .result_rd_o    (result_rd_o),
    .result_we_o    (result_we_o),
    .count_o        (count_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // reference model: per-ID state plus an issue-order queue
  bit            m_busy [NI];
  bit            m_done [NI];
  logic [DW-1:0] m_data [NI];
  logic [RW-1:0] m_rd   [NI];
  int            m_q [$];
  bit            m_err;
  bit            e_ready;
  bit            e_valid;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_data[i] = '0; m_rd[i] = '0;
    end
    m_q.delete();
    m_err = 0;
  endtask

  task automatic drive(input bit fl, input bit av, input int aid,
                       input int ard, input bit wv, input int wid,
                       input logic [DW-1:0] wd, input bit rr);
    flush_i = fl;
    alloc_valid_i = av;
    alloc_id_i = IW'(aid);
    alloc_rd_i = RW'(ard);
    wb_valid_i = wv;
    wb_id_i = IW'(wid);
    wb_data_i = wd;
    result_ready_i = rr;
    @(negedge clk_i);
    e_ready = !fl && m_q.size() < QD && !m_busy[aid];
    e_valid = !fl && m_q.size() != 0 && m_done[m_q.size() ? m_q[0] : 0];
  endtask

  task automatic advance();
    bit fa, fp, ok;
    @(posedge clk_i);
    if (flush_i) begin
      for (int i = 0; i < NI; i++) begin m_busy[i] = 0; m_done[i] = 0; end
      m_q.delete();
      m_err = 0;
    end else begin
      fa = alloc_valid_i && e_ready;
      fp = e_valid && result_ready_i;
      ok = wb_valid_i && m_busy[wb_id_i] && !m_done[wb_id_i];
      m_err = wb_valid_i && !ok;
      if (ok) begin m_data[wb_id_i] = wb_data_i; m_done[wb_id_i] = 1; end
      if (fp) begin
        m_busy[m_q[0]] = 0; m_done[m_q[0]] = 0;
        void'(m_q.pop_front());
      end
      if (fa) begin
        m_q.push_back(int'(alloc_id_i));
        m_busy[alloc_id_i] = 1; m_done[alloc_id_i] = 0;
        m_rd[alloc_id_i] = alloc_rd_i;
      end
    end
    #1;
  endtask

  task automatic idle(input bit rr);
    drive(0, 0, 0, 0, 0, 0, '0, rr);
  endtask

  task automatic test_reset();
    rst_ni = 1;
    #1 rst_ni = 0;
    #1;
    checks++;
    if ({alloc_ready_o, result_valid_o, result_we_o, err_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {alloc_ready_o, result_valid_o, result_we_o, err_o});
    end
    checks++;
    if ({count_o, result_id_o, result_rd_o, result_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_fields cnt=%0d id=%0d rd=%0d data=%h exp=0",
               count_o, result_id_o, result_rd_o, result_data_o);
    end
    model_reset();
    @(negedge clk_i) rst_ni = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic();
    drive(0, 1, 2, 5, 0, 0, '0, 1);
    checks++;
    if (alloc_ready_o !== 1'b1) begin
      errors++; $display("FAIL basic_ready got=%b exp=1", alloc_ready_o);
    end
    advance();
    drive(0, 0, 0, 0, 1, 2, 32'hDEADBEEF, 1);
    checks++;
    if (result_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_nobypass got=%b exp=0", result_valid_o);
    end
    advance();
    idle(1);
    checks++;
    if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o}
        !== {1'b1, 3'd2, 5'd5, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL basic_result v=%b id=%0d rd=%0d we=%b d=%h exp 1/2/5/1/deadbeef",
               result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o);
    end
    advance();
    idle(1);
    checks++;
    if (count_o !== 3'd0) begin
      errors++; $display("FAIL basic_count got=%0d exp=0", count_o);
    end
    advance();
  endtask

  task automatic test_ooo();
    int al[3] = '{1, 3, 0};
    int wb[3] = '{0, 3, 1};
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, al[i], i + 1, 0, 0, '0, 1);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, wb[i], DW'(32'h100 + wb[i]), 1);
      checks++;
      if (result_valid_o !== 1'b0) begin
        errors++; $display("FAIL ooo_early step=%0d got=%b exp=0", i, result_valid_o);
      end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checks++;
      if (result_valid_o !== 1'b1 || result_id_o !== IW'(al[i])
          || result_data_o !== DW'(32'h100 + al[i])) begin
        errors++;
        $display("FAIL ooo_order step=%0d v=%b id=%0d d=%h exp id=%0d",
                 i, result_valid_o, result_id_o, result_data_o, al[i]);
      end
      advance();
    end
    idle(1);
    checks++;
    if (count_o !== 3'd0 || result_valid_o !== 1'b0) begin
      errors++; $display("FAIL ooo_drain cnt=%0d v=%b exp 0/0", count_o, result_valid_o);
    end
    advance();
  endtask

  task automatic test_full();
    drive(0, 1, 4, 1, 0, 0, '0, 0); advance();
    drive(0, 1, 4, 1, 0, 0, '0, 0);
    checks++;
    if (alloc_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_dup got=%b exp=0", alloc_ready_o);
    end
    advance();
    for (int i = 5; i < 8; i++) begin drive(0, 1, i, 1, 0, 0, '0, 0); advance(); end
    drive(0, 1, 0, 1, 0, 0, '0, 0);
    checks++;
    if (alloc_ready_o !== 1'b0 || count_o !== 3'd4) begin
      errors++; $display("FAIL full_5th rdy=%b cnt=%0d exp 0/4", alloc_ready_o, count_o);
    end
    advance();
    drive(0, 0, 0, 0, 1, 4, 32'h44, 0); advance();
    drive(0, 0, 0, 0, 1, 5, 32'h55, 0); advance();
    drive(0, 0, 0, 0, 0, 0, '0, 1); advance();
    drive(0, 1, 5, 2, 0, 0, '0, 1);
    checks++;
    if (alloc_ready_o !== 1'b0 || result_valid_o !== 1'b1 || count_o !== 3'd3) begin
      errors++;
      $display("FAIL full_popcycle rdy=%b v=%b cnt=%0d exp 0/1/3",
               alloc_ready_o, result_valid_o, count_o);
    end
    advance();
    drive(0, 1, 5, 2, 0, 0, '0, 0);
    checks++;
    if (alloc_ready_o !== 1'b1 || count_o !== 3'd2) begin
      errors++; $display("FAIL full_realloc rdy=%b cnt=%0d exp 1/2", alloc_ready_o, count_o);
    end
    advance();
    drive(1, 0, 0, 0, 0, 0, '0, 0); advance();
  endtask

  task automatic test_backpressure();
    drive(0, 1, 3, 0, 0, 0, '0, 0); advance();
    drive(0, 0, 0, 0, 1, 3, 32'hCAFE0123, 0); advance();
    for (int i = 0; i < 5; i++) begin
      idle(0);
      checks++;
      if ({result_valid_o, result_id_o, result_we_o, result_data_o}
          !== {1'b1, 3'd3, 1'b0, 32'hCAFE0123}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d v=%b id=%0d we=%b d=%h exp 1/3/0/cafe0123",
                 i, result_valid_o, result_id_o, result_we_o, result_data_o);
      end
      advance();
    end
    idle(1); advance();
    idle(0);
    checks++;
    if (result_valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL bp_single v=%b cnt=%0d exp 0/0", result_valid_o, count_o);
    end
    advance();
  endtask

  task automatic test_illegal();
    drive(0, 0, 0, 0, 1, 6, 32'h666, 0); advance();
    idle(0);
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL ill_unalloc got=%b exp=1", err_o);
    end
    advance();
    drive(0, 1, 2, 7, 0, 0, '0, 0);
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL ill_pulse got=%b exp=0", err_o);
    end
    advance();
    drive(0, 0, 0, 0, 1, 2, 32'hAAAA, 0); advance();
    drive(0, 0, 0, 0, 1, 2, 32'hBBBB, 0); advance();
    idle(0);
    checks++;
    if (err_o !== 1'b1 || result_data_o !== 32'hAAAA) begin
      errors++; $display("FAIL ill_done err=%b d=%h exp 1/aaaa", err_o, result_data_o);
    end
    advance();
    idle(1);
    checks++;
    if (err_o !== 1'b0 || result_valid_o !== 1'b1) begin
      errors++; $display("FAIL ill_after err=%b v=%b exp 0/1", err_o, result_valid_o);
    end
    advance();
  endtask

  task automatic test_flush();
    for (int i = 1; i < 4; i++) begin drive(0, 1, i, i, 0, 0, '0, 0); advance(); end
    drive(0, 0, 0, 0, 1, 2, 32'h22, 0); advance();
    drive(1, 1, 4, 1, 1, 7, 32'h77, 1);
    checks++;
    if (alloc_ready_o !== 1'b0 || result_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_cycle rdy=%b v=%b exp 0/0", alloc_ready_o, result_valid_o);
    end
    advance();
    idle(0);
    checks++;
    if (count_o !== 3'd0 || result_valid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_after cnt=%0d v=%b err=%b exp 0/0/0", count_o, result_valid_o, err_o);
    end
    advance();
    for (int i = 0; i < NI; i++) begin
      drive(0, 0, i, 0, 0, 0, '0, 0);
      checks++;
      if (alloc_ready_o !== 1'b1) begin
        errors++; $display("FAIL flush_realloc id=%0d got=%b exp=1", i, alloc_ready_o);
      end
      advance();
    end
  endtask

  task automatic test_random();
    int wid;
    int h;
    for (int c = 0; c < 400; c++) begin
      wid = $urandom_range(0, NI - 1);
      if (m_q.size() != 0 && $urandom_range(0, 3) != 0)
        wid = m_q[$urandom_range(0, m_q.size() - 1)];
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 1), $urandom_range(0, NI - 1),
            $urandom_range(0, 31), $urandom_range(0, 2) != 0, wid, $urandom,
            $urandom_range(0, 2) != 0);
      h = m_q.size() ? m_q[0] : 0;
      checks++;
      if (alloc_ready_o !== e_ready || result_valid_o !== e_valid
          || count_o !== CW'(m_q.size()) || err_o !== m_err) begin
        errors++;
        $display("FAIL rnd_ctrl cyc=%0d rdy=%b/%b v=%b/%b cnt=%0d/%0d err=%b/%b",
                 c, alloc_ready_o, e_ready, result_valid_o, e_valid,
                 count_o, m_q.size(), err_o, m_err);
      end
      if (e_valid) begin
        checks++;
        if (result_id_o !== IW'(h) || result_data_o !== m_data[h]
            || result_rd_o !== m_rd[h] || result_we_o !== (m_rd[h] != 0)) begin
          errors++;
          $display("FAIL rnd_payload cyc=%0d id=%0d/%0d d=%h/%h rd=%0d/%0d we=%b",
                   c, result_id_o, h, result_data_o, m_data[h],
                   result_rd_o, m_rd[h], result_we_o);
        end
      end
      advance();
    end
    #2 rst_ni = 0;
    #1;
    checks++;
    if (count_o !== 3'd0 || result_valid_o !== 1'b0 || alloc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset cnt=%0d v=%b rdy=%b exp 0/0/0",
               count_o, result_valid_o, alloc_ready_o);
    end
    model_reset();
    @(negedge clk_i) rst_ni = 1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ooo();
    test_full();
    test_backpressure();
    test_illegal();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_result_buffer.md
Name: id_result_buffer

Overview:
- Parametrised result buffer for the CV-X-IF MAC coprocessor. It is the successor to the single-register ID store.
- Allocates an entry per offloaded instruction ID in issue order and accepts out-of-order writebacks keyed by ID.
- Retires results strictly in issue order onto the CV-X-IF result interface using a valid/ready handshake.
- Sits between the coprocessor decoder/issue logic and the MAC datapath writeback.

Parameters:
IdWidth, 3, width of instruction ID; ID space = 2**IdWidth entries (matches X_ID_WIDTH)
DataWidth, 32, result data width
RdWidth, 5, destination register address width
QueueDepth, 4, max outstanding instructions; power of two, 2 <= QueueDepth <= 2**IdWidth

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  discard all outstanding entries
alloc_valid_i  in  1  request to allocate an ID
alloc_ready_o  out  1  allocation accepted this cycle when high with alloc_valid_i
alloc_id_i  in  IdWidth  ID being allocated
alloc_rd_i  in  RdWidth  destination register for that ID
wb_valid_i  in  1  datapath writeback strobe
wb_id_i  in  IdWidth  writeback ID
wb_data_i  in  DataWidth  writeback data
result_valid_o  out  1  head result available
result_ready_i  in  1  consumer accepts result
result_id_o  out  IdWidth  head ID
result_data_o  out  DataWidth  head data
result_rd_o  out  RdWidth  head destination register
result_we_o  out  1  head writes RF (rd != 0)
count_o  out  $clog2(QueueDepth)+1  outstanding entries
err_o  out  1  one-cycle pulse: illegal writeback dropped

Behaviour:
- Reset: rst_ni is asynchronous and active-low; clk_i is the clock. On reset all busy/done bits, data, rd, FIFO pointers and count clear to 0. All outputs are 0 in reset.
- State per ID: busy, done, data, rd. An order FIFO of QueueDepth IDs holds issue order, with rd/wr pointers and a count.
- alloc_ready_o = !flush_i && count < QueueDepth && !busy[alloc_id_i]. This is combinational from current state only.
- On an accepted allocation, at the clock edge:
  - busy = 1, done = 0, rd = alloc_rd_i.
  - The ID is pushed to the FIFO.
  - An ID popped in the same cycle is still busy, so it cannot be re-allocated in that cycle.
- Writeback when busy[wb_id_i] && !done[wb_id_i]: store data and set done at the edge.
- Writeback when the ID is not busy, or is already done: the write is dropped and err_o pulses high in the next cycle.
- Writeback latency: done is visible on result_valid_o one cycle after wb_valid_i. There is no combinational bypass.
- result_valid_o = !flush_i && count != 0 && done[head_id]. The result_* fields always show the head entry; they are don't-care when not valid.
- Pop occurs on result_valid_o && result_ready_i. Busy and done of the head ID clear at the edge, and the read pointer advances.
- Once result_valid_o is asserted, it holds with stable payload until accepted.
- Simultaneous events:
  - Allocation and pop in the same cycle: count unchanged.
  - Writeback to the head ID in the same cycle as a pop attempt: impossible, because the head ID is already done, so this is an illegal writeback and raises err_o.
  - Writeback and allocation of the same ID in the same cycle: the writeback is illegal (not yet busy) and raises err_o.
- Flush: flush_i has priority over everything in that cycle. At the edge, all busy/done bits and pointers clear and count becomes 0. Allocation, writeback and pop in the flush cycle are ignored, and no err_o is raised.
- Pointers wrap modulo QueueDepth.
- Reset mid-operation: immediate clear. Outstanding results are lost, and the upstream kill logic is responsible for those instructions.

Decomposition:
- Shared package (coprocessor MAC package, or cvxif_pkg where fields already exist) holds:
  - the id_entry_t struct {busy, done, rd, data};
  - the default-width constants.
- One natural sub-module: id_order_fifo. It is a parametrised pointer FIFO of IDs with push, pop, flush, count, head and full/empty.
- The entry array and the handshake stay in the top level.

Test Plan:
- Basic path, QueueDepth=4. Alloc ID 2 with rd=5, then wb ID 2 with data 0xDEADBEEF, ready held high. Required: result_valid_o high 1 cycle after wb, id=2, rd=5, we=1, data 0xDEADBEEF; count returns to 0.
- Out-of-order writeback. Alloc 1, 3, 0; wb order 0, 3, 1; ready held high. Required: results emerge only after wb 1, in order 1, 3, 0, on consecutive cycles.
- Full and duplicate ID. Alloc 4 distinct IDs. Required: alloc_ready_o low for a 5th request. A duplicate of a busy ID is refused even when count < 4. After one pop, that ID can be allocated in the following cycle but not in the pop cycle.
- Backpressure. Head done, result_ready_i low for 5 cycles. Required: valid and payload stable for all 5 cycles; single pop when ready rises.
- Illegal writeback. wb ID 6 when not allocated, then a second wb to an already-done ID. Required: err_o pulses once per case; stored data unchanged.
- Flush. 3 outstanding entries, 1 done; flush_i asserted together with alloc_valid_i and result_ready_i. Required: next cycle count=0, result_valid_o=0, the allocation is not taken, and all IDs are re-allocatable.
